// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the multi-channel clock divider.
//   MAX_CH      : largest supported channel count
//   DEFAULT_DIV : divisor loaded into every channel at reset
//   ch_w()      : width of the channel-select field, never narrower than 1 bit
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int MAX_CH      = 16;
  localparam int DEFAULT_DIV = 2200;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: counts 0..div_q and toggles sclk at the terminal count.
// A newly written divisor waits in pend_div until a terminal count, a restart
// (disable or sync), so sclk never produces a shortened half-period.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   en        : run enable; low holds the channel in its restart state
//   sync      : restart request (phase alignment), tied low when unused
//   wr/wr_div : divisor write strobe and value for this channel
//   sclk      : divided square wave, half-period div_q+1 cycles
//   tick      : one-cycle pulse on the cycle sclk is first seen high
//   pend      : a written divisor has not yet been adopted
// -----------------------------------------------------------------------------
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int             DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(clk_div_pkg::DEFAULT_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             sclk,
  output logic             tick,
  output logic             pend
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pend_div;

  logic             restart;
  logic             terminal;
  logic             adopt;
  logic             have_new;
  logic [DIV_W-1:0] next_div;

  assign restart  = ~en | sync;
  assign terminal = (cnt == div_q);
  assign adopt    = restart | terminal;
  // A write landing on an adoption cycle is taken directly, bypassing pend_div.
  assign have_new = wr | pend;
  assign next_div = wr ? wr_div : pend_div;

  // NOTE: every register here is assigned with <= so all channel state updates
  // together from pre-edge values; blocking assignments would let later lines
  // see already-updated state and break the terminal/adopt ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sclk     <= 1'b0;
      tick     <= 1'b0;
      pend     <= 1'b0;
      div_q    <= DEFAULT_DIV;
      pend_div <= DEFAULT_DIV;
    end else begin
      if (restart) begin
        cnt  <= '0;
        sclk <= 1'b0;
        tick <= 1'b0;
      end else if (terminal) begin
        cnt  <= '0;
        sclk <= ~sclk;
        tick <= ~sclk;  // high only on the 0->1 toggle
      end else begin
        cnt  <= cnt + DIV_W'(1);
        tick <= 1'b0;
      end

      if (adopt) begin
        if (have_new) begin
          div_q    <= next_div;
          pend_div <= next_div;
        end
        pend <= 1'b0;
      end else if (wr) begin
        pend_div <= wr_div;  // last write before adoption wins
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// N_CH independent runtime-programmable clock dividers sharing one config port.
// Optional feature macro: CLK_DIV_SYNC_EN adds sync_in, which restarts every
// enabled channel together so channels with equal divisors stay in phase.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   en         : per-channel run enable
//   cfg_valid  : divisor write request
//   cfg_ready  : write accepted when cfg_valid & cfg_ready (low only in reset)
//   cfg_ch     : target channel; values >= N_CH are ignored
//   cfg_div    : new divisor
//   sync_in    : (CLK_DIV_SYNC_EN only) phase-align all enabled channels
//   pend       : per-channel written divisor not yet in effect
//   sclk       : per-channel divided square wave
//   tick       : per-channel one-cycle rising-edge strobe
// -----------------------------------------------------------------------------
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ch_w(N_CH)-1:0]    cfg_ch,
  input  logic [DIV_W-1:0]         cfg_div,
`ifdef CLK_DIV_SYNC_EN
  input  logic                     sync_in,
`endif
  output logic [N_CH-1:0]          pend,
  output logic [N_CH-1:0]          sclk,
  output logic [N_CH-1:0]          tick
);

  localparam int CH_W = ch_w(N_CH);

  logic sync;
  logic cfg_fire;

`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  assign cfg_fire = cfg_valid & cfg_ready;

  // Ready drops only while reset is applied; there is no backpressure.
  always_ff @(posedge clk) begin
    if (rst) cfg_ready <= 1'b0;
    else     cfg_ready <= 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    logic wr;
    // Out-of-range cfg_ch matches no channel, so such writes vanish.
    assign wr = cfg_fire & (cfg_ch == CH_W'(i));

    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DIV_W'(DEFAULT_DIV))
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .sync   (sync),
      .wr     (wr),
      .wr_div (cfg_div),
      .sclk   (sclk[i]),
      .tick   (tick[i]),
      .pend   (pend[i])
    );
  end

endmodule
